fifo_rd_arbiter: RTL and testbench

//  Shares the async FIFO read port between N_REQ consumers in the rd_clk domain.

---
 rtl/fifo_rd_arb_pkg.sv | 15 +
 rtl/fifo_rr_arb.sv | 32 +++
 rtl/fifo_rd_arbiter.sv | 143 ++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_arb_pkg.sv
// Shared constants, state type and helpers for the FIFO read-port arbiter.
package fifo_rd_arb_pkg;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned BURST_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} arb_state_t;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_arb.sv
// Round-robin picker: first requester strictly after ptr wins; returns its one-hot grant and index.
module fifo_rr_arb
  import fifo_rd_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] next_ptr
);

  logic             found;
  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = PTR_W'((32'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        next_ptr  = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Shares an async FIFO read port between N_REQ consumers with round-robin bursts.
// Optional FIFO_RD_ARB_ERR_CNT_EN adds a saturating rd_err counter output err_cnt.
module fifo_rd_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = fifo_rd_arb_pkg::WIDTH,
  parameter int unsigned BURST_W = fifo_rd_arb_pkg::BURST_W
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*BURST_W-1:0] req_len,
  output logic [N_REQ-1:0]         gnt,
  output logic                     done,
  output logic                     burst_err,
  output logic [WIDTH-1:0]         cons_data,
  output logic [N_REQ-1:0]         cons_valid,
  output logic                     rd_en,
  input  logic                     empty,
  input  logic                     almost_empty,
  input  logic                     rd_ack,
  input  logic                     rd_err,
  input  logic [WIDTH-1:0]         dout
`ifdef FIFO_RD_ARB_ERR_CNT_EN
  ,
  output logic [7:0]               err_cnt
`endif
);

  import fifo_rd_arb_pkg::*;

  localparam int unsigned PTR_W = idx_w(N_REQ);

  arb_state_t         state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d, pick_gnt;
  logic [PTR_W-1:0]   ptr_q, ptr_d, pick_idx;
  logic [BURST_W-1:0] issue_q, issue_d, ack_q, ack_d, issue_rem, ack_rem;
  logic               rd_en_q, rd_en_d, done_q, done_d, berr_q, berr_d;
  logic [BURST_W-1:0] len_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_len
    assign len_arr[g] = req_len[g*BURST_W +: BURST_W];
  end

  fifo_rr_arb #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req      (req),
    .ptr      (ptr_q),
    .gnt      (pick_gnt),
    .next_ptr (pick_idx)
  );

  always_comb begin
    // Counts as they stand after this cycle's read/ack are accounted for.
    issue_rem = issue_q - BURST_W'(rd_en_q);
    ack_rem   = (rd_ack && ack_q != '0) ? ack_q - BURST_W'(1) : ack_q;
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    issue_d   = issue_q;
    ack_d     = ack_q;
    rd_en_d   = 1'b0;
    done_d    = 1'b0;
    berr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = pick_gnt;
          ptr_d   = pick_idx;
          issue_d = len_arr[pick_idx];
          ack_d   = len_arr[pick_idx];
          state_d = BURST;
        end
      end
      BURST, DRAIN: begin
        issue_d = issue_rem;
        ack_d   = ack_rem;
        if (rd_err) begin
          gnt_d   = '0;
          issue_d = '0;
          ack_d   = '0;
          done_d  = 1'b1;
          berr_d  = 1'b1;
          state_d = IDLE;
        end else if (issue_rem == '0 && ack_rem == '0) begin
          gnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          // A read taken at almost_empty may leave empty stale for a cycle: insert a bubble.
          rd_en_d = (issue_rem != '0) && !empty && !(rd_en_q && almost_empty);
          state_d = (issue_rem != '0) ? BURST : DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= PTR_W'(N_REQ - 1);
      issue_q <= '0;
      ack_q   <= '0;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      issue_q <= issue_d;
      ack_q   <= ack_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
      berr_q  <= berr_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign burst_err  = berr_q;
  assign rd_en      = rd_en_q;
  assign cons_data  = dout;
  assign cons_valid = gnt_q & {N_REQ{rd_ack}};

`ifdef FIFO_RD_ARB_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      err_cnt_q <= '0;
    end else if (rd_err && err_cnt_q != 8'hff) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with a behavioural FIFO read-port model.
module tb_fifo_rd_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned BW = 5;

  logic            rd_clk, rd_rst;
  logic [N-1:0]    req;
  logic [N*BW-1:0] req_len;
  logic [N-1:0]    gnt, cons_valid;
  logic            done, burst_err, rd_en;
  logic [W-1:0]    cons_data, dout;
  logic            empty, almost_empty, rd_ack, rd_err, err_q, force_err;
`ifdef FIFO_RD_ARB_ERR_CNT_EN
  logic [7:0]      err_cnt;
`endif

  fifo_rd_arbiter #(
    .N_REQ   (N),
    .WIDTH   (W),
    .BURST_W (BW)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .req          (req),
    .req_len      (req_len),
    .gnt          (gnt),
    .done         (done),
    .burst_err    (burst_err),
    .cons_data    (cons_data),
    .cons_valid   (cons_valid),
    .rd_en        (rd_en),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_ack       (rd_ack),
    .rd_err       (rd_err),
    .dout         (dout)
`ifdef FIFO_RD_ARB_ERR_CNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // FIFO model: ack/data one cycle after rd_en, rd_err on an empty read.
  logic [7:0] mem [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  assign empty        = (wr_ptr == rd_ptr);
  assign almost_empty = ((wr_ptr - rd_ptr) <= 1);
  assign rd_err       = err_q | force_err;

  initial begin
    rd_ack = 1'b0;
    err_q  = 1'b0;
    dout   = '0;
  end

  always @(posedge rd_clk) begin
    rd_ack <= 1'b0;
    err_q  <= 1'b0;
    if (rd_en) begin
      if (wr_ptr == rd_ptr) begin
        err_q <= 1'b1;
      end else begin
        dout   <= mem[rd_ptr[7:0]];
        rd_ack <= 1'b1;
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  int n_rd = 0;
  int n_err = 0;
  int n_cv [N];

  initial for (int i = 0; i < N; i++) n_cv[i] = 0;

  always @(negedge rd_clk) begin
    if (rd_en) n_rd++;
    if (rd_err) n_err++;
    for (int i = 0; i < N; i++) if (cons_valid[i]) n_cv[i]++;
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fifo_write(input int n);
    for (int k = 0; k < n; k++) begin
      mem[wr_ptr[7:0]] = 8'hA0 + 8'(wr_ptr);
      wr_ptr++;
    end
  endtask

  task automatic set_len(input int i, input int v);
    req_len[i*BW +: BW] = BW'(v);
  endtask

  task automatic do_reset();
    rd_rst    = 1'b1;
    force_err = 1'b0;
    req       = '0;
    repeat (2) @(negedge rd_clk);
    rd_rst = 1'b0;
  endtask

  // Samples each negedge until done; returns at the done sample, before the next edge.
  task automatic run_burst(input int budget, output logic [N-1:0] g_first,
                           output logic [15:0] pat, output logic berr,
                           output logic [7:0] d_first, output logic [7:0] d_last);
    logic seen, got;
    seen = 1'b0; got = 1'b0; g_first = '0; pat = '0; berr = 1'b0; d_first = '0; d_last = '0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge rd_clk);
      if (c == 0) g_first = gnt;
      pat = {pat[14:0], rd_en};
      if (|cons_valid) begin
        if (!got) d_first = cons_data;
        got    = 1'b1;
        d_last = cons_data;
      end
      if (done) begin
        seen = 1'b1;
        berr = burst_err;
      end
    end
    check_eq("done_within_budget", 32'(seen), 32'd1);
  endtask

  logic [N-1:0] gf;
  logic [15:0]  pat;
  logic         be;
  logic [7:0]   d0, d1;
  logic [3:0]   p4;
  int           rd0, cv0, er0;

  initial begin
    rd_rst = 1'b1; req = '0; req_len = '0; force_err = 1'b0;
    do_reset();
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_burst_err", 32'(burst_err), 32'd0);
    check_eq("rst_rd_en", 32'(rd_en), 32'd0);
    check_eq("rst_cons_valid", 32'(cons_valid), 32'd0);
`ifdef FIFO_RD_ARB_ERR_CNT_EN
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif

    // Single consumer, len 3, FIFO holds 8.
    fifo_write(8);
    rd0 = n_rd; cv0 = n_cv[0];
    set_len(0, 3); req = 4'b0001;
    run_burst(30, gf, pat, be, d0, d1);
    req = '0;
    check_eq("t1_gnt", 32'(gf), 32'h1);
    check_eq("t1_rd_en_pattern", 32'(pat), 32'h1C);
    check_eq("t1_rd_count", 32'(n_rd - rd0), 32'd3);
    check_eq("t1_cv0_count", 32'(n_cv[0] - cv0), 32'd3);
    check_eq("t1_first_data", 32'(d0), 32'hA0);
    check_eq("t1_last_data", 32'(d1), 32'hA2);
    check_eq("t1_burst_err", 32'(be), 32'd0);
    check_eq("t1_words_left", 32'(wr_ptr - rd_ptr), 32'd5);

    // All four requesting, len 2 each: round-robin from req[0].
    do_reset();
    fifo_write(5);
    for (int i = 0; i < N; i++) set_len(i, 2);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cv0 = n_cv[k % N];
      run_burst(30, gf, pat, be, d0, d1);
      if (k == 4) req = '0;
      check_eq($sformatf("t2_gnt_%0d", k), 32'(gf), 32'(1 << (k % N)));
      check_eq($sformatf("t2_cv_%0d", k), 32'(n_cv[k % N] - cv0), 32'd2);
    end

    // One word present, len 4: stall on empty, resume after refill.
    fifo_write(1);
    rd0 = n_rd; cv0 = n_cv[0]; er0 = n_err;
    set_len(0, 4); req = 4'b0001;
    repeat (8) @(negedge rd_clk);
    check_eq("t3_stalled_rd_count", 32'(n_rd - rd0), 32'd1);
    check_eq("t3_stalled_rd_en", 32'(rd_en), 32'd0);
    check_eq("t3_stalled_gnt", 32'(gnt), 32'h1);
    fifo_write(3);
    run_burst(40, gf, pat, be, d0, d1);
    req = '0;
    check_eq("t3_rd_count", 32'(n_rd - rd0), 32'd4);
    check_eq("t3_cv0_count", 32'(n_cv[0] - cv0), 32'd4);
    check_eq("t3_no_rd_err", 32'(n_err - er0), 32'd0);
    check_eq("t3_burst_err", 32'(be), 32'd0);

    // Read taken at almost_empty forces a bubble before the next read.
    fifo_write(1);
    cv0 = n_cv[0]; er0 = n_err;
    set_len(0, 2); req = 4'b0001;
    @(negedge rd_clk); p4[3] = rd_en;
    @(negedge rd_clk); p4[2] = rd_en;
    @(negedge rd_clk); p4[1] = rd_en;
    fifo_write(1);
    @(negedge rd_clk); p4[0] = rd_en;
    run_burst(20, gf, pat, be, d0, d1);
    req = '0;
    check_eq("t4_rd_en_pattern", 32'(p4), 32'h5);
    check_eq("t4_cv0_count", 32'(n_cv[0] - cv0), 32'd2);
    check_eq("t4_no_rd_err", 32'(n_err - er0), 32'd0);
    check_eq("t4_burst_err", 32'(be), 32'd0);

    // rd_err in the burst's second cycle aborts it.
    do_reset();
    fifo_write(8);
    set_len(0, 4); req = 4'b0001;
    @(negedge rd_clk);
    check_eq("t5_gnt", 32'(gnt), 32'h1);
    @(negedge rd_clk);
    check_eq("t5_rd_en_before", 32'(rd_en), 32'd1);
    force_err = 1'b1;
    @(negedge rd_clk);
    force_err = 1'b0; req = '0;
    check_eq("t5_rd_en_after", 32'(rd_en), 32'd0);
    check_eq("t5_done", 32'(done), 32'd1);
    check_eq("t5_burst_err", 32'(burst_err), 32'd1);
    check_eq("t5_gnt_cleared", 32'(gnt), 32'd0);
    check_eq("t5_cons_valid", 32'(cons_valid), 32'd0);
`ifdef FIFO_RD_ARB_ERR_CNT_EN
    check_eq("t5_err_cnt", 32'(err_cnt), 32'd1);
`endif
    @(negedge rd_clk);
    check_eq("t5_done_pulse", 32'(done), 32'd0);

    // Reset mid-burst, then re-arbitration starts at req[0].
    fifo_write(8);
    set_len(1, 8); req = 4'b0010;
    repeat (3) @(negedge rd_clk);
    rd_rst = 1'b1;
    @(negedge rd_clk);
    check_eq("t6_gnt", 32'(gnt), 32'd0);
    check_eq("t6_done", 32'(done), 32'd0);
    check_eq("t6_burst_err", 32'(burst_err), 32'd0);
    check_eq("t6_rd_en", 32'(rd_en), 32'd0);
    check_eq("t6_cons_valid", 32'(cons_valid), 32'd0);
`ifdef FIFO_RD_ARB_ERR_CNT_EN
    check_eq("t6_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rd_rst = 1'b0;
    for (int i = 0; i < N; i++) set_len(i, 1);
    req = 4'b1111;
    run_burst(30, gf, pat, be, d0, d1);
    req = '0;
    check_eq("t6_regrant", 32'(gf), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
